// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load-store requests onto an 8-bit RAM/IO bus.
// Optional feature macro MEMC_IO_STALL_EN: stalls write beats to the IO region while io_buffer_full is set.
module mem_ctrl #(
    parameter int         IF_BYTES = 4,
    parameter logic [1:0] IO_HI    = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_en,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_en,
    input  logic        lsb_rw,
    input  logic [31:0] lsb_addr,
    input  logic [2:0]  lsb_len,
    input  logic [31:0] lsb_w_data,
    output logic        lsb_done,
    output logic [31:0] lsb_r_data
);

`ifdef MEMC_IO_STALL_EN
    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, IO_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;
`endif

    state_t      state_q;
    state_t      state_d;

    logic [2:0]  cnt_q;
    logic [31:0] base_q;
    logic [2:0]  len_q;
    logic [31:0] wdata_q;
    logic [31:0] acc_q;

    logic        pend_valid_q;
    logic        pend_rw_q;
    logic [31:0] pend_addr_q;
    logic [2:0]  pend_len_q;
    logic [31:0] pend_data_q;

    logic        if_done_q;
    logic        lsb_done_q;
    logic [31:0] if_data_q;
    logic [31:0] lsb_r_data_q;

    logic [31:0] beat_addr;
    logic        rd_last;
    logic        wr_last;
    logic        take_pend;
    logic        take_if;
    logic        write_beat;
    logic [1:0]  rd_idx;
    logic [4:0]  wr_sel;
    logic [31:0] acc_next;

    assign beat_addr = base_q + {29'd0, cnt_q};
    assign rd_last   = (cnt_q >= len_q);
    assign wr_last   = (({1'b0, cnt_q} + 4'd1) >= {1'b0, len_q});
    assign rd_idx    = cnt_q[1:0] - 2'd1;
    assign wr_sel    = {cnt_q[1:0], 3'b000};

`ifdef MEMC_IO_STALL_EN
    logic io_block;
    assign io_block = (beat_addr[17:16] == IO_HI) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full ^ (beat_addr[17:16] == IO_HI);
`endif

    // Read data trails its address by one cycle, so the byte landing now belongs to beat cnt-1.
    always_comb begin
        acc_next = acc_q;
        acc_next[{rd_idx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    // A pending store survives rollback; loads and fetches are speculative and dropped.
    always_comb begin
        state_d   = state_q;
        take_pend = 1'b0;
        take_if   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_valid_q && (pend_rw_q || !rollback)) begin
                    take_pend = 1'b1;
                    state_d   = pend_rw_q ? LS_WR : LS_RD;
                end else if (if_en && !rollback) begin
                    take_if = 1'b1;
                    state_d = IF_RD;
                end
            end
            IF_RD, LS_RD: begin
                if (rollback || rd_last) begin
                    state_d = IDLE;
                end
            end
            LS_WR: begin
`ifdef MEMC_IO_STALL_EN
                if (io_block) begin
                    state_d = IO_WAIT;
                end else if (wr_last) begin
                    state_d = IDLE;
                end
`else
                if (wr_last) begin
                    state_d = IDLE;
                end
`endif
            end
`ifdef MEMC_IO_STALL_EN
            IO_WAIT: begin
                if (!io_buffer_full) begin
                    state_d = wr_last ? IDLE : LS_WR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_a      = 32'd0;
        mem_dout   = 8'd0;
        write_beat = 1'b0;
        case (state_q)
            IF_RD, LS_RD: begin
                if (!rd_last) begin
                    mem_a = beat_addr;
                end
            end
            LS_WR: begin
                mem_a    = beat_addr;
                mem_dout = wdata_q[wr_sel +: 8];
`ifdef MEMC_IO_STALL_EN
                write_beat = !io_block;
`else
                write_beat = 1'b1;
`endif
            end
`ifdef MEMC_IO_STALL_EN
            IO_WAIT: begin
                mem_a      = beat_addr;
                mem_dout   = wdata_q[wr_sel +: 8];
                write_beat = !io_buffer_full;
            end
`endif
            default: ;
        endcase
    end

    assign mem_wr     = write_beat & rdy;
    assign if_done    = if_done_q & rdy;
    assign lsb_done   = lsb_done_q & rdy;
    assign if_data    = if_data_q;
    assign lsb_r_data = lsb_r_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= 3'd0;
            base_q       <= 32'd0;
            len_q        <= 3'd0;
            wdata_q      <= 32'd0;
            acc_q        <= 32'd0;
            pend_valid_q <= 1'b0;
            pend_rw_q    <= 1'b0;
            pend_addr_q  <= 32'd0;
            pend_len_q   <= 3'd0;
            pend_data_q  <= 32'd0;
            if_done_q    <= 1'b0;
            lsb_done_q   <= 1'b0;
            if_data_q    <= 32'd0;
            lsb_r_data_q <= 32'd0;
        end else if (rdy) begin
            if_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;

            if (take_pend || (rollback && !pend_rw_q)) begin
                pend_valid_q <= 1'b0;
            end
            if (lsb_en && (lsb_rw || !rollback)) begin
                pend_valid_q <= 1'b1;
                pend_rw_q    <= lsb_rw;
                pend_addr_q  <= lsb_addr;
                pend_len_q   <= lsb_len;
                pend_data_q  <= lsb_w_data;
            end

            if (take_pend) begin
                base_q  <= pend_addr_q;
                len_q   <= pend_len_q;
                wdata_q <= pend_data_q;
                cnt_q   <= 3'd0;
                acc_q   <= 32'd0;
            end else if (take_if) begin
                base_q <= if_addr;
                len_q  <= 3'(IF_BYTES);
                cnt_q  <= 3'd0;
                acc_q  <= 32'd0;
            end

            case (state_q)
                IF_RD, LS_RD: begin
                    if (!rollback) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q != 3'd0) begin
                            acc_q <= acc_next;
                        end
                        if (rd_last) begin
                            if (state_q == IF_RD) begin
                                if_done_q <= 1'b1;
                                if_data_q <= acc_next;
                            end else begin
                                lsb_done_q   <= 1'b1;
                                lsb_r_data_q <= acc_next;
                            end
                        end
                    end
                end
                LS_WR: begin
                    if (write_beat) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (wr_last) begin
                            lsb_done_q <= 1'b1;
                        end
                    end
                end
`ifdef MEMC_IO_STALL_EN
                IO_WAIT: begin
                    if (write_beat) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (wr_last) begin
                            lsb_done_q <= 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a small byte RAM model whose read data lags the address by one cycle.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_en = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_en = 1'b0;
    logic        lsb_rw = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [2:0]  lsb_len = 3'd0;
    logic [31:0] lsb_w_data = 32'd0;
    logic        lsb_done;
    logic [31:0] lsb_r_data;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  ram [0:1023];
    logic [31:0] last_a = 32'd0;

`ifdef MEMC_IO_STALL_EN
    localparam int IO_WR_C = 4;
`else
    localparam int IO_WR_C = 1;
`endif

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_rw(lsb_rw), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data)
    );

    always #5 clk = ~clk;

    // RAM model: address sampled mid-cycle, data presented just after the following edge.
    always @(negedge clk) begin
        last_a = mem_a;
        if (mem_wr === 1'b1) ram[mem_a[9:0]] = mem_dout;
    end

    always @(posedge clk) begin
        #1;
        mem_din = ram[last_a[9:0]];
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (mem_a !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_mem_a got %h want 0", mem_a); end
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_wr got %b want 0", mem_wr); end
        n_checks++; if (mem_dout !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_mem_dout got %h want 0", mem_dout); end
        n_checks++; if (if_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_if_done got %b want 0", if_done); end
        n_checks++; if (lsb_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_lsb_done got %b want 0", lsb_done); end
        n_checks++; if (if_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_if_data got %h want 0", if_data); end
        n_checks++; if (lsb_r_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_lsb_r_data got %h want 0", lsb_r_data); end
    endtask

    task automatic test_lsb_load();
        logic [31:0] exp_a;
        for (int c = -1; c <= 8; c++) begin
            lsb_en = (c == -1); lsb_rw = 1'b0; lsb_addr = 32'h100; lsb_len = 3'd4; lsb_w_data = 32'd0;
            @(negedge clk);
            n_checks++;
            if (lsb_done !== (c == 6)) begin n_fail++; $display("[TB] FAIL load_done c=%0d got %b want %b", c, lsb_done, (c == 6)); end
            n_checks++;
            if (mem_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL load_mem_wr c=%0d got %b want 0", c, mem_wr); end
            if (c >= 1 && c <= 4) begin
                exp_a = 32'(32'h100 + c - 1);
                n_checks++;
                if (mem_a !== exp_a) begin n_fail++; $display("[TB] FAIL load_addr c=%0d got %h want %h", c, mem_a, exp_a); end
            end
            if (c == 6) begin
                n_checks++;
                if (lsb_r_data !== 32'h44332211) begin n_fail++; $display("[TB] FAIL load_data got %h want 44332211", lsb_r_data); end
            end
            next_cycle();
        end
    endtask

    task automatic test_lsb_store();
        logic [31:0] exp_a;
        logic [7:0]  exp_d;
        for (int c = -1; c <= 5; c++) begin
            lsb_en = (c == -1); lsb_rw = 1'b1; lsb_addr = 32'h1FE; lsb_len = 3'd2; lsb_w_data = 32'hAABBCCDD;
            @(negedge clk);
            n_checks++;
            if (mem_wr !== (c == 1 || c == 2)) begin n_fail++; $display("[TB] FAIL store_mem_wr c=%0d got %b want %b", c, mem_wr, (c == 1 || c == 2)); end
            n_checks++;
            if (lsb_done !== (c == 3)) begin n_fail++; $display("[TB] FAIL store_done c=%0d got %b want %b", c, lsb_done, (c == 3)); end
            if (c == 1 || c == 2) begin
                exp_a = 32'(32'h1FE + c - 1);
                exp_d = (c == 1) ? 8'hDD : 8'hCC;
                n_checks++;
                if (mem_a !== exp_a) begin n_fail++; $display("[TB] FAIL store_addr c=%0d got %h want %h", c, mem_a, exp_a); end
                n_checks++;
                if (mem_dout !== exp_d) begin n_fail++; $display("[TB] FAIL store_dout c=%0d got %h want %h", c, mem_dout, exp_d); end
            end
            next_cycle();
        end
        lsb_rw = 1'b0;
        n_checks++; if (ram[10'h1FE] !== 8'hDD) begin n_fail++; $display("[TB] FAIL store_ram0 got %h want dd", ram[10'h1FE]); end
        n_checks++; if (ram[10'h1FF] !== 8'hCC) begin n_fail++; $display("[TB] FAIL store_ram1 got %h want cc", ram[10'h1FF]); end
        n_checks++; if (lsb_r_data !== 32'h44332211) begin n_fail++; $display("[TB] FAIL store_hold_rdata got %h want 44332211", lsb_r_data); end
    endtask

    task automatic test_back_to_back();
        logic        fetch_on = 1'b1;
        logic [31:0] exp_a;
        for (int c = 0; c <= 14; c++) begin
            if_en = fetch_on; if_addr = 32'h200;
            lsb_en = (c == 2); lsb_rw = 1'b0; lsb_addr = 32'h204; lsb_len = 3'd4;
            @(negedge clk);
            n_checks++;
            if (if_done !== (c == 6)) begin n_fail++; $display("[TB] FAIL b2b_if_done c=%0d got %b want %b", c, if_done, (c == 6)); end
            n_checks++;
            if (lsb_done !== (c == 12)) begin n_fail++; $display("[TB] FAIL b2b_lsb_done c=%0d got %b want %b", c, lsb_done, (c == 12)); end
            if (if_done === 1'b1) begin fetch_on = 1'b0; if_en = 1'b0; end
            exp_a = 32'd0;
            if (c >= 1 && c <= 4) exp_a = 32'(32'h200 + c - 1);
            if (c >= 7 && c <= 10) exp_a = 32'(32'h204 + c - 7);
            if ((c >= 1 && c <= 4) || (c >= 7 && c <= 10) || c == 0 || c == 6 || c >= 12) begin
                n_checks++;
                if (mem_a !== exp_a) begin n_fail++; $display("[TB] FAIL b2b_addr c=%0d got %h want %h", c, mem_a, exp_a); end
            end
            if (c == 6) begin
                n_checks++;
                if (if_data !== 32'hD4C3B2A1) begin n_fail++; $display("[TB] FAIL b2b_if_data got %h want d4c3b2a1", if_data); end
            end
            if (c == 12) begin
                n_checks++;
                if (lsb_r_data !== 32'h1807F6E5) begin n_fail++; $display("[TB] FAIL b2b_lsb_data got %h want 1807f6e5", lsb_r_data); end
            end
            next_cycle();
        end
        if_en = 1'b0; lsb_en = 1'b0;
    endtask

    task automatic test_rollback();
        logic [31:0] exp_a;
        for (int c = 0; c <= 20; c++) begin
            if_en = (c <= 2); if_addr = 32'h200;
            rollback = (c == 3 || c == 14);
            lsb_en = (c == 1 || c == 14);
            lsb_rw = (c == 1); lsb_addr = (c == 1) ? 32'h300 : 32'h100;
            lsb_len = (c == 1) ? 3'd1 : 3'd4; lsb_w_data = 32'h0000005A;
            @(negedge clk);
            n_checks++;
            if (if_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_if_done c=%0d got %b want 0", c, if_done); end
            n_checks++;
            if (lsb_done !== (c == 6)) begin n_fail++; $display("[TB] FAIL rb_lsb_done c=%0d got %b want %b", c, lsb_done, (c == 6)); end
            n_checks++;
            if (mem_wr !== (c == 5)) begin n_fail++; $display("[TB] FAIL rb_mem_wr c=%0d got %b want %b", c, mem_wr, (c == 5)); end
            if (c == 1 || c == 2 || c == 5 || c >= 6) begin
                exp_a = 32'd0;
                if (c == 1 || c == 2) exp_a = 32'(32'h200 + c - 1);
                if (c == 5) exp_a = 32'h300;
                n_checks++;
                if (mem_a !== exp_a) begin n_fail++; $display("[TB] FAIL rb_addr c=%0d got %h want %h", c, mem_a, exp_a); end
            end
            if (c == 5) begin
                n_checks++;
                if (mem_dout !== 8'h5A) begin n_fail++; $display("[TB] FAIL rb_dout got %h want 5a", mem_dout); end
            end
            next_cycle();
        end
        rollback = 1'b0; lsb_en = 1'b0; lsb_rw = 1'b0; if_en = 1'b0;
    endtask

    task automatic test_rdy();
        for (int c = -1; c <= 7; c++) begin
            lsb_en = (c == -1); lsb_rw = 1'b1; lsb_addr = 32'h310; lsb_len = 3'd2; lsb_w_data = 32'h00009988;
            rdy = !(c == 2 || c == 4);
            @(negedge clk);
            n_checks++;
            if (mem_wr !== (c == 1 || c == 3)) begin n_fail++; $display("[TB] FAIL rdy_mem_wr c=%0d got %b want %b", c, mem_wr, (c == 1 || c == 3)); end
            n_checks++;
            if (lsb_done !== (c == 5)) begin n_fail++; $display("[TB] FAIL rdy_done c=%0d got %b want %b", c, lsb_done, (c == 5)); end
            if (c == 1 || c == 3) begin
                n_checks++;
                if (mem_a !== ((c == 1) ? 32'h310 : 32'h311)) begin n_fail++; $display("[TB] FAIL rdy_addr c=%0d got %h", c, mem_a); end
                n_checks++;
                if (mem_dout !== ((c == 1) ? 8'h88 : 8'h99)) begin n_fail++; $display("[TB] FAIL rdy_dout c=%0d got %h", c, mem_dout); end
            end
            next_cycle();
        end
        rdy = 1'b1; lsb_rw = 1'b0;
    endtask

    task automatic test_io_stall();
        for (int c = -1; c <= 7; c++) begin
            lsb_en = (c == -1); lsb_rw = 1'b1; lsb_addr = 32'h00030000; lsb_len = 3'd1; lsb_w_data = 32'h00000077;
            io_buffer_full = (c >= 1 && c <= 3);
            @(negedge clk);
            n_checks++;
            if (mem_wr !== (c == IO_WR_C)) begin n_fail++; $display("[TB] FAIL io_mem_wr c=%0d got %b want %b", c, mem_wr, (c == IO_WR_C)); end
            n_checks++;
            if (lsb_done !== (c == IO_WR_C + 1)) begin n_fail++; $display("[TB] FAIL io_done c=%0d got %b want %b", c, lsb_done, (c == IO_WR_C + 1)); end
            if (c == IO_WR_C) begin
                n_checks++;
                if (mem_a !== 32'h00030000) begin n_fail++; $display("[TB] FAIL io_addr got %h want 00030000", mem_a); end
            end
            next_cycle();
        end
        io_buffer_full = 1'b0; lsb_rw = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        for (int c = -1; c <= 2; c++) begin
            lsb_en = (c == -1); lsb_rw = 1'b0; lsb_addr = 32'h100; lsb_len = 3'd4;
            next_cycle();
        end
        lsb_en = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (mem_a !== 32'd0) begin n_fail++; $display("[TB] FAIL rmid_mem_a got %h want 0", mem_a); end
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_mem_wr got %b want 0", mem_wr); end
        n_checks++; if (mem_dout !== 8'd0) begin n_fail++; $display("[TB] FAIL rmid_mem_dout got %h want 0", mem_dout); end
        n_checks++; if (if_data !== 32'd0) begin n_fail++; $display("[TB] FAIL rmid_if_data got %h want 0", if_data); end
        n_checks++; if (lsb_r_data !== 32'd0) begin n_fail++; $display("[TB] FAIL rmid_lsb_r_data got %h want 0", lsb_r_data); end
        n_checks++; if (lsb_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_lsb_done got %b want 0", lsb_done); end
        next_cycle();
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (lsb_done !== 1'b0 || if_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_post_done c=%0d got %b%b want 00", c, lsb_done, if_done); end
            n_checks++;
            if (mem_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_post_wr c=%0d got %b want 0", c, mem_wr); end
            next_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'(i ^ 8'h5A);
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h200] = 8'hA1; ram[10'h201] = 8'hB2; ram[10'h202] = 8'hC3; ram[10'h203] = 8'hD4;
        ram[10'h204] = 8'hE5; ram[10'h205] = 8'hF6; ram[10'h206] = 8'h07; ram[10'h207] = 8'h18;

        $display("[TB] starting mem_ctrl directed tests");
        test_reset();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        test_lsb_load();
        test_lsb_store();
        test_back_to_back();
        test_rollback();
        test_rdy();
        test_io_stall();
        test_reset_mid_read();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the core and the single-port RAM/IO bus. It arbitrates between instruction fetch (level request, held until done) and the load-store buffer (one-cycle request pulse). It splits each access into 1/2/4 byte beats on the 8-bit bus and returns assembled little-endian data with a one-cycle done pulse. Rollback aborts speculative reads; committed stores always complete.

## Interface
Parameters:
- IF_BYTES, 4 — bytes per instruction fetch; 4 only in this revision.
- IO_HI, 2'b11 — value of addr[17:16] that marks the IO region.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low freezes all state.
- rollback  in  1  mispredict flush.
- mem_din  in  8  RAM read byte; valid the cycle after its address.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write beat.
- io_buffer_full  in  1  IO sink full; used only with the macro.
- if_en  in  1  fetch request; level, held until if_done.
- if_addr  in  32  fetch address.
- if_done  out  1  one-cycle fetch completion.
- if_data  out  32  fetched word.
- lsb_en  in  1  LSB request pulse.
- lsb_rw  in  1  1 = store.
- lsb_addr  in  32  access address.
- lsb_len  in  3  1, 2 or 4 bytes.
- lsb_w_data  in  32  store data; low lsb_len bytes are used.
- lsb_done  out  1  one-cycle LSB completion.
- lsb_r_data  out  32  load data, zero-extended raw bytes.

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR, IO_WAIT (IO_WAIT exists only with the macro).
- Pending slot: an lsb_en pulse is always captured (rw, addr, len, data) into one pending register. The LSB never issues a second request before lsb_done, so there is never more than one outstanding.
- IDLE priority: pending LSB first, then if_en. A pending store goes to LS_WR, a pending load to LS_RD, a fetch to IF_RD.
- Beat counter: 3 bits, beat i uses mem_a = base + i (32-bit wrap).
- Reads: issue n addresses, then capture byte i into bits [8i+7:8i].
- Writes: mem_dout = byte i, mem_wr = 1 for n beats.
- Rollback:
  - IF_RD or LS_RD go to IDLE immediately with no done pulse; a pending load and fetch arbitration are discarded.
  - LS_WR, IO_WAIT and a pending store are unaffected.
  - An lsb_en load in the same cycle as rollback is ignored; an lsb_en store is captured.
- rdy low: state, counter and data are held; mem_wr is forced 0 and done outputs are 0.
- Reset outputs: mem_dout = 0, mem_a = 0, mem_wr = 0, if_done = 0, if_data = 0, lsb_done = 0, lsb_r_data = 0. State is IDLE and the pending slot is empty.
- In IDLE: mem_a = 0, mem_wr = 0.

## Timing
- Cycle 0 is the cycle a request is taken from IDLE.
- Read of n bytes:
  - mem_a = base + i - 1 in cycles 1..n.
  - Byte i - 1 is sampled at the end of cycle i + 1.
  - done and data are visible in cycle n + 2.
  - State is IDLE in cycle n + 2, so a new grant can occur in cycle n + 2.
- Write of n bytes: mem_wr = 1 in cycles 1..n; lsb_done in cycle n + 1.
- Fetch: 4 bytes, so if_done is in cycle 6.
- if_data and lsb_r_data hold their value until the next completion of the same port.
- An lsb_en pulse in the cycle of any done is still captured.
- If if_en drops before done, the fetch finishes anyway; if_done still pulses and upstream ignores it.

## Configuration
- MEMC_IO_STALL_EN defined: before each write beat whose address has addr[17:16] == IO_HI, if io_buffer_full is 1 the controller enters IO_WAIT with mem_wr = 0. It resumes the same beat in the first cycle io_buffer_full is 0.
- Undefined: io_buffer_full is ignored and IO_WAIT is never entered.

## Test plan
- LSB load, len 4, addr 0x100, RAM bytes 11 22 33 44 → mem_a 0x100..0x103 in cycles 1–4; lsb_done in cycle 6 with lsb_r_data = 0x44332211.
- LSB store, len 2, addr 0x1FE, data 0xAABBCCDD → writes DD@0x1FE and CC@0x1FF with mem_wr = 1; lsb_done in cycle 3; no further writes.
- if_en held and an lsb_en load arrives in fetch cycle 2 → fetch completes (if_done cycle 6); the load is granted next and lsb_done follows 6 cycles later.
- Rollback in cycle 3 of a fetch, with a store pending → no if_done; the store executes and lsb_done pulses; no fetch beats are issued until if_en is reasserted.
- With MEMC_IO_STALL_EN, a len 1 store to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then one write beat; lsb_done one cycle later.
- Reset asserted mid-read → all outputs go to zero values immediately; after release, no done pulse and mem_wr = 0.
